// File: rtl/io_flag_unit_if.sv
// Device-side bundle of the basic computer I/O unit:
// keyboard input channel and printer output channel.
interface io_flag_unit_if #(
    parameter int DATA_W = 8
);
    logic              kb_valid;
    logic [DATA_W-1:0] kb_data;
    logic              kb_ready;
    logic              prn_valid;
    logic [DATA_W-1:0] prn_data;
    logic              prn_ready;

    // Devices: keyboard source and printer sink
    modport master (
        output kb_valid, kb_data, prn_ready,
        input  kb_ready, prn_valid, prn_data
    );

    // The I/O flag unit itself
    modport slave (
        input  kb_valid, kb_data, prn_ready,
        output kb_ready, prn_valid, prn_data
    );
endinterface

// File: rtl/io_flag_unit.sv
// Basic computer I/O unit: INPR/OUTR, FGI/FGO flags,
// interrupt flip-flop R and printer handshake FSM.
module io_flag_unit #(
    parameter int DATA_W  = 8,
    parameter int PRN_GAP = 3
) (
    input  logic              clk,
    input  logic              reset,
    io_flag_unit_if.slave     io,
    input  logic              inp_take,
    input  logic              out_load,
    input  logic [DATA_W-1:0] ac_in,
    input  logic              ien,
    input  logic              r_chk,
    input  logic              r_clr,
    output logic [DATA_W-1:0] inpr,
    output logic              fgi,
    output logic              fgo,
    output logic              r,
    output logic              in_ovr,
    output logic              out_ovr
);
    localparam int CNT_W = (PRN_GAP < 2) ? 1 : $clog2(PRN_GAP + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } prn_state_e;

    prn_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] inpr_q, inpr_d;
    logic [DATA_W-1:0] outr_q, outr_d;
    logic              fgi_q, fgi_d;
    logic              fgo_q, fgo_d;
    logic              r_q, r_d;
    logic              prn_valid_q, prn_valid_d;
    logic              in_ovr_q, in_ovr_d;
    logic              out_ovr_q, out_ovr_d;
    logic              kb_accept;

    // Keyboard side, INP strobe, interrupt flip-flop and sticky overrun bits
    always_comb begin
        kb_accept = io.kb_valid & ~fgi_q;
        inpr_d    = inpr_q;
        fgi_d     = fgi_q;
        in_ovr_d  = in_ovr_q | (inp_take & ~fgi_q);
        out_ovr_d = out_ovr_q | (out_load & ~fgo_q);
        if (kb_accept) begin
            inpr_d = io.kb_data;
            fgi_d  = 1'b1;
        end else if (inp_take && fgi_q) begin
            fgi_d = 1'b0;
        end
        // Set condition uses pre-edge flag values
        if (r_clr) begin
            r_d = 1'b0;
        end else if (r_chk && ien && (fgi_q || fgo_q)) begin
            r_d = 1'b1;
        end else begin
            r_d = r_q;
        end
    end

    // Printer FSM: load OUTR, hold it until accepted, then recover
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        outr_d      = outr_q;
        fgo_d       = fgo_q;
        prn_valid_d = prn_valid_q;
        unique case (state_q)
            IDLE: begin
                if (out_load) begin
                    outr_d      = ac_in;
                    fgo_d       = 1'b0;
                    prn_valid_d = 1'b1;
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (io.prn_ready) begin
                    prn_valid_d = 1'b0;
                    if (PRN_GAP == 0) begin
                        fgo_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d   = CNT_W'(PRN_GAP);
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (cnt_q <= CNT_W'(1)) begin
                    fgo_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                fgo_d       = 1'b1;
                prn_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State registers; reset takes effect without waiting for a clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            inpr_q      <= '0;
            outr_q      <= '0;
            fgi_q       <= 1'b0;
            fgo_q       <= 1'b1;
            r_q         <= 1'b0;
            prn_valid_q <= 1'b0;
            in_ovr_q    <= 1'b0;
            out_ovr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            inpr_q      <= inpr_d;
            outr_q      <= outr_d;
            fgi_q       <= fgi_d;
            fgo_q       <= fgo_d;
            r_q         <= r_d;
            prn_valid_q <= prn_valid_d;
            in_ovr_q    <= in_ovr_d;
            out_ovr_q   <= out_ovr_d;
        end
    end

    assign io.kb_ready  = ~fgi_q;
    assign io.prn_valid = prn_valid_q;
    assign io.prn_data  = outr_q;
    assign inpr         = inpr_q;
    assign fgi          = fgi_q;
    assign fgo          = fgo_q;
    assign r            = r_q;
    assign in_ovr       = in_ovr_q;
    assign out_ovr      = out_ovr_q;
endmodule

// File: tb/tb_io_flag_unit.sv
// Self-checking bench for io_flag_unit: direct flag checks
// plus a scoreboard of characters expected at the printer.
`timescale 1ns/1ps
module tb_io_flag_unit;
    localparam int DATA_W  = 8;
    localparam int PRN_GAP = 3;

    logic              clk;
    logic              reset;
    logic              inp_take;
    logic              out_load;
    logic [DATA_W-1:0] ac_in;
    logic              ien;
    logic              r_chk;
    logic              r_clr;
    logic [DATA_W-1:0] inpr;
    logic              fgi;
    logic              fgo;
    logic              r;
    logic              in_ovr;
    logic              out_ovr;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] prn_q[$];

    io_flag_unit_if #(.DATA_W(DATA_W)) io ();

    io_flag_unit #(
        .DATA_W (DATA_W),
        .PRN_GAP(PRN_GAP)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .io      (io.slave),
        .inp_take(inp_take),
        .out_load(out_load),
        .ac_in   (ac_in),
        .ien     (ien),
        .r_chk   (r_chk),
        .r_clr   (r_clr),
        .inpr    (inpr),
        .fgi     (fgi),
        .fgo     (fgo),
        .r       (r),
        .in_ovr  (in_ovr),
        .out_ovr (out_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; sample 1ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Printer monitor: a handshake at the coming edge pops the scoreboard
    always @(negedge clk) begin
        if (!reset && io.prn_valid && io.prn_ready) begin
            if (prn_q.size() == 0)
                check("prn_extra", 32'(io.prn_data), 32'hFFFF_FFFF);
            else
                check("prn_data", 32'(io.prn_data), 32'(prn_q.pop_front()));
        end
    end

    initial begin
        reset       = 1'b1;
        io.kb_valid = 1'b0;
        io.kb_data  = '0;
        io.prn_ready = 1'b0;
        inp_take    = 1'b0;
        out_load    = 1'b0;
        ac_in       = '0;
        ien         = 1'b0;
        r_chk       = 1'b0;
        r_clr       = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst_fgo", 32'(fgo), 32'd1);
        check("rst_fgi", 32'(fgi), 32'd0);
        check("rst_r", 32'(r), 32'd0);
        check("rst_pv", 32'(io.prn_valid), 32'd0);
        check("rst_kbr", 32'(io.kb_ready), 32'd1);
        check("rst_inpr", 32'(inpr), 32'h00);
        check("rst_iovr", 32'(in_ovr), 32'd0);
        check("rst_oovr", 32'(out_ovr), 32'd0);

        // Keyboard character in, second offer refused while fgi=1
        io.kb_valid = 1'b1;
        io.kb_data  = 8'h41;
        tick();
        check("kb1_inpr", 32'(inpr), 32'h41);
        check("kb1_fgi", 32'(fgi), 32'd1);
        check("kb1_kbr", 32'(io.kb_ready), 32'd0);
        io.kb_data = 8'h42;
        tick();
        check("kb2_hold", 32'(inpr), 32'h41);
        inp_take = 1'b1;
        tick();
        inp_take = 1'b0;
        check("inp_fgi", 32'(fgi), 32'd0);
        check("inp_inpr", 32'(inpr), 32'h41);
        tick();
        io.kb_valid = 1'b0;
        check("kb2_inpr", 32'(inpr), 32'h42);
        check("kb2_fgi", 32'(fgi), 32'd1);
        inp_take = 1'b1;
        tick();
        inp_take = 1'b0;
        check("inp2_fgi", 32'(fgi), 32'd0);

        // Printer transfer with a slow printer
        out_load = 1'b1;
        ac_in    = 8'h5A;
        prn_q.push_back(8'h5A);
        tick();
        out_load = 1'b0;
        check("out_fgo", 32'(fgo), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("send_pv", 32'(io.prn_valid), 32'd1);
            check("send_pd", 32'(io.prn_data), 32'h5A);
            if (i == 1) begin
                out_load = 1'b1;
                ac_in    = 8'h11;
                inp_take = 1'b1;
            end
            tick();
            out_load = 1'b0;
            inp_take = 1'b0;
        end
        check("oovr", 32'(out_ovr), 32'd1);
        check("iovr", 32'(in_ovr), 32'd1);
        check("iovr_inpr", 32'(inpr), 32'h42);
        check("oovr_pd", 32'(io.prn_data), 32'h5A);
        io.prn_ready = 1'b1;
        tick();
        io.prn_ready = 1'b0;
        check("hs_pv", 32'(io.prn_valid), 32'd0);
        for (int i = 0; i < PRN_GAP - 1; i++) begin
            check("gap_fgo", 32'(fgo), 32'd0);
            tick();
        end
        check("gap_fgo_last", 32'(fgo), 32'd0);
        tick();
        check("gap_fgo_set", 32'(fgo), 32'd1);
        check("sticky_oovr", 32'(out_ovr), 32'd1);

        // Interrupt flip-flop
        ien   = 1'b1;
        r_chk = 1'b1;
        tick();
        check("r_set", 32'(r), 32'd1);
        r_clr = 1'b1;
        tick();
        check("r_clr", 32'(r), 32'd0);
        tick();
        check("r_clr_prio", 32'(r), 32'd0);
        r_clr = 1'b0;
        r_chk = 1'b0;
        ien   = 1'b0;
        io.kb_valid = 1'b1;
        io.kb_data  = 8'h55;
        tick();
        io.kb_valid = 1'b0;
        check("kb3_fgi", 32'(fgi), 32'd1);
        r_chk = 1'b1;
        tick();
        tick();
        r_chk = 1'b0;
        check("r_no_ien", 32'(r), 32'd0);

        // Asynchronous reset in the middle of a transfer
        out_load = 1'b1;
        ac_in    = 8'h33;
        prn_q.push_back(8'h33);
        tick();
        out_load = 1'b0;
        check("s33_pv", 32'(io.prn_valid), 32'd1);
        check("s33_pd", 32'(io.prn_data), 32'h33);
        #3;
        reset = 1'b1;
        #1;
        check("arst_pv", 32'(io.prn_valid), 32'd0);
        check("arst_fgo", 32'(fgo), 32'd1);
        check("arst_oovr", 32'(out_ovr), 32'd0);
        prn_q.delete();
        tick();
        reset = 1'b0;
        tick();
        check("arst_inpr", 32'(inpr), 32'h00);
        check("arst_fgi", 32'(fgi), 32'd0);

        // Fresh transfer after reset with a fast printer
        out_load = 1'b1;
        ac_in    = 8'h77;
        prn_q.push_back(8'h77);
        tick();
        out_load     = 1'b0;
        io.prn_ready = 1'b1;
        check("s77_pd", 32'(io.prn_data), 32'h77);
        tick();
        io.prn_ready = 1'b0;
        check("s77_pv", 32'(io.prn_valid), 32'd0);
        for (int i = 0; i < 10 && !fgo; i++) tick();
        check("s77_fgo", 32'(fgo), 32'd1);
        check("oovr_clean", 32'(out_ovr), 32'd0);
        check("prn_q_empty", 32'(prn_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/io_flag_unit.md
Name: io_flag_unit

Overview:
- Input/output interface of the basic computer, directly upstream of the control unit.
- Captures keyboard characters into INPR and drives the FGI_in/FGO_in flags and the interrupt flip-flop R that the CU consumes.
- Takes the CU's INP/OUT strobes and hands OUTR to the printer over a valid/ready handshake.

Parameters:
- DATA_W, 8, width of INPR, OUTR and the device data buses.
- PRN_GAP, 3, printer recovery cycles after a character is accepted, before FGO is set again (0 allowed).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- kb_valid  input  1  keyboard offers kb_data.
- kb_data  input  DATA_W  keyboard character.
- kb_ready  output  1  unit can accept a keyboard character.
- inp_take  input  1  CU executes INP (AC<-INPR); one-cycle strobe.
- out_load  input  1  CU executes OUT (OUTR<-AC); one-cycle strobe.
- ac_in  input  DATA_W  AC low bits, sampled on out_load.
- ien  input  1  CU interrupt-enable flip-flop.
- r_chk  input  1  CU timing phase outside T0..T2; R may be set.
- r_clr  input  1  CU clears R at the end of the interrupt cycle.
- inpr  output  DATA_W  INPR contents to the AC path.
- fgi  output  1  input flag (to CU FGI_in).
- fgo  output  1  output flag (to CU FGO_in).
- r  output  1  interrupt flip-flop (to CU r).
- prn_valid  output  1  printer data valid.
- prn_data  output  DATA_W  OUTR contents.
- prn_ready  input  1  printer accepts prn_data.
- in_ovr  output  1  sticky: inp_take seen while fgi=0.
- out_ovr  output  1  sticky: out_load seen while fgo=0.

Behaviour:
- Reset (asynchronous, immediate):
  - inpr=0, OUTR=0, fgi=0, fgo=1, r=0, prn_valid=0, in_ovr=0, out_ovr=0.
  - Printer FSM returns to IDLE and the gap counter clears.
  - Reset asserted mid-transfer drops prn_valid in the same cycle; the character is lost.
- Keyboard side:
  - kb_ready = ~fgi (combinational).
  - On a clock edge with kb_valid & kb_ready: INPR<=kb_data, fgi<=1.
- INP:
  - inp_take with fgi=1: fgi<=0 next edge; INPR is held.
  - inp_take with fgi=0: no data or flag change; in_ovr<=1.
  - kb accept and inp_take cannot coincide, because kb_ready=0 whenever fgi=1.
  - A new character is accepted no earlier than the cycle after fgi clears.
- Printer FSM, states IDLE, SEND, GAP:
  - IDLE (fgo=1, prn_valid=0):
    - out_load -> OUTR<=ac_in, fgo<=0, prn_valid<=1, go to SEND.
  - SEND:
    - prn_valid=1; prn_data=OUTR held stable until accepted.
    - prn_ready=1 -> prn_valid<=0, go to GAP with counter=PRN_GAP; if PRN_GAP=0, go straight to IDLE with fgo<=1.
  - GAP:
    - Counter decrements each cycle.
    - When the counter reaches 1, next state is IDLE and fgo<=1.
    - Total from handshake edge to fgo=1 is PRN_GAP+1 edges, minimum 1.
  - out_load while fgo=0 (SEND or GAP): ignored, OUTR unchanged, out_ovr<=1.
  - prn_ready while not in SEND: ignored.
- Interrupt flip-flop R:
  - At each edge: if r_clr then r<=0; else if r_chk & ien & (fgi|fgo) then r<=1; else r holds.
  - r_clr has priority over set.
  - Flag values used for the set are the current-cycle values, before that edge's updates.
- Outputs:
  - All outputs except kb_ready are registered.
  - Sticky bits clear only on reset.
  - Flags update one edge after the causing strobe or handshake.

Test Plan:
- Reset with prn_ready=0, then release -> fgo=1, fgi=0, r=0, prn_valid=0, kb_ready=1, inpr=0x00.
- kb_valid=1, kb_data=0x41 for one cycle -> next edge inpr=0x41, fgi=1, kb_ready=0. A second offer of 0x42 is not taken. inp_take pulse -> fgi=0 next edge; 0x42 then accepted, inpr=0x42.
- out_load with ac_in=0x5A, prn_ready held 0 for 4 cycles then 1 -> prn_valid=1 and prn_data=0x5A stable throughout. prn_valid=0 after the handshake edge. With PRN_GAP=3, fgo=1 exactly 4 edges after the handshake.
- out_load while fgo=0, ac_in=0x11 -> OUTR stays 0x5A, out_ovr=1. inp_take while fgi=0 -> in_ovr=1, inpr unchanged.
- ien=1, fgo=1, r_chk=1 -> r=1 next edge. Same cycle with r_clr=1 -> r stays 0. ien=0 with fgi=1 -> r stays 0.
- Assert reset asynchronously (between edges) during SEND with 0x33 pending -> prn_valid=0 and fgo=1 immediately, without waiting for a clock. After release, a new out_load of 0x77 transfers normally.
